// File: rtl/conv_row_feeder.sv
// Buffers a raster pixel stream in a 4-row ring and issues zero-padded
// 3-row windows to the conv engine, one window per output row.
module conv_row_feeder #(
  parameter int D          = 4,
  parameter int H          = 12,
  parameter int W          = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            rstn_i,
  input  logic [DATA_WIDTH*D-1:0]         pix_i,
  input  logic                            pix_valid_i,
  output logic                            pix_ready_o,
  output logic [DATA_WIDTH*D*(W+2)-1:0]   image0_o,
  output logic [DATA_WIDTH*D*(W+2)-1:0]   image1_o,
  output logic [DATA_WIDTH*D*(W+2)-1:0]   image2_o,
  output logic                            image_start_o,
  input  logic                            conv_done_i,
  output logic [$clog2(H)-1:0]            row_idx_o,
  output logic                            frame_done_o,
  output logic                            busy_o
);

  localparam int BEAT_W = DATA_WIDTH * D;
  localparam int IMG_W  = DATA_WIDTH * D * (W + 2);
  localparam int CW     = (W > 1) ? $clog2(W) : 1;
  localparam int RW     = $clog2(H + 3);
  localparam int RIW    = $clog2(H);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_DONE_LAST} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     col_in, col_in_n;
  logic [RW-1:0]     row_in, row_in_n;
  logic [RW-1:0]     out_row, out_row_n;
  logic [RW-1:0]     need_rows;
  logic [BEAT_W-1:0] ring [4][W];
  logic              accept;
  logic              capture;
  logic              last_done;
  logic [1:0]        slot0, slot1, slot2;
  logic [IMG_W-1:0]  win0, win1, win2;

  assign accept        = pix_valid_i && pix_ready_o;
  assign image_start_o = (state == ISSUE);
  assign need_rows     = (out_row + RW'(2) > RW'(H)) ? RW'(H) : out_row + RW'(2);

  // Row storage is plain data and deliberately keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (accept) ring[row_in[1:0]][col_in] <= pix_i;
  end

  assign slot0 = 2'(out_row - RW'(1));
  assign slot1 = out_row[1:0];
  assign slot2 = 2'(out_row + RW'(1));

  always_comb begin
    win0 = '0;
    win1 = '0;
    win2 = '0;
    for (int j = 0; j < W; j++) begin
      for (int i = 0; i < D; i++) begin
        win0[DATA_WIDTH*((W+2)*i + j + 1) +: DATA_WIDTH] = ring[slot0][j][DATA_WIDTH*i +: DATA_WIDTH];
        win1[DATA_WIDTH*((W+2)*i + j + 1) +: DATA_WIDTH] = ring[slot1][j][DATA_WIDTH*i +: DATA_WIDTH];
        win2[DATA_WIDTH*((W+2)*i + j + 1) +: DATA_WIDTH] = ring[slot2][j][DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
    // Rows outside the image are vertical zero padding.
    if (out_row == '0) win0 = '0;
    if (out_row == RW'(H - 1)) win2 = '0;
  end

  always_comb begin
    state_n   = state;
    col_in_n  = col_in;
    row_in_n  = row_in;
    out_row_n = out_row;
    capture   = 1'b0;
    last_done = 1'b0;
    if (accept) begin
      if (col_in == CW'(W - 1)) begin
        col_in_n = '0;
        row_in_n = row_in + RW'(1);
      end else begin
        col_in_n = col_in + CW'(1);
      end
    end
    unique case (state)
      IDLE: begin
        if (row_in >= need_rows) begin
          capture = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        out_row_n = out_row + RW'(1);
        state_n   = (out_row == RW'(H - 1)) ? WAIT_DONE_LAST : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conv_done_i) state_n = IDLE;
      end
      WAIT_DONE_LAST: begin
        if (conv_done_i) begin
          last_done = 1'b1;
          state_n   = IDLE;
          col_in_n  = '0;
          row_in_n  = '0;
          out_row_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Control registers; ready is computed from next-state values so it is exact.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= IDLE;
      col_in       <= '0;
      row_in       <= '0;
      out_row      <= '0;
      pix_ready_o  <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state        <= state_n;
      col_in       <= col_in_n;
      row_in       <= row_in_n;
      out_row      <= out_row_n;
      pix_ready_o  <= (row_in_n <= out_row_n + RW'(2)) && (row_in_n < RW'(H)) &&
                      (state_n != WAIT_DONE_LAST);
      frame_done_o <= last_done;
      if (last_done)   busy_o <= 1'b0;
      else if (accept) busy_o <= 1'b1;
    end
  end

  // Window capture stage: held until the next capture.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      image0_o  <= '0;
      image1_o  <= '0;
      image2_o  <= '0;
      row_idx_o <= '0;
    end else if (capture) begin
      image0_o  <= win0;
      image1_o  <= win1;
      image2_o  <= win2;
      row_idx_o <= out_row[RIW-1:0];
    end
  end

endmodule

// File: tb/tb_conv_row_feeder.sv
// Directed bench for conv_row_feeder: a window model derived from the pixel
// numbering checks every issued window, plus literal spot checks.
module tb_conv_row_feeder;

  localparam int D     = 4;
  localparam int H     = 12;
  localparam int W     = 12;
  localparam int DW    = 8;
  localparam int IMG_W = DW * D * (W + 2);

  logic             clk;
  logic             rstn_i;
  logic [DW*D-1:0]  pix_i;
  logic             pix_valid_i;
  logic             pix_ready_o;
  logic [IMG_W-1:0] image0_o, image1_o, image2_o;
  logic             image_start_o;
  logic             conv_done_i;
  logic [3:0]       row_idx_o;
  logic             frame_done_o;
  logic             busy_o;

  int total = 0;
  int bad   = 0;
  int exp_row;
  int next_beat;
  bit manual_done = 0;
  bit auto_done   = 0;
  int done_cnt    = 0;

  conv_row_feeder #(.D(D), .H(H), .W(W), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn_i(rstn_i), .pix_i(pix_i), .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o), .image0_o(image0_o), .image1_o(image1_o),
    .image2_o(image2_o), .image_start_o(image_start_o), .conv_done_i(conv_done_i),
    .row_idx_o(row_idx_o), .frame_done_o(frame_done_o), .busy_o(busy_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_img(input string nm, input logic [IMG_W-1:0] act, input logic [IMG_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pixel numbering: channel 0 = row*W+col+1 (= beat index + 1), channel i = i.
  function automatic logic [DW*D-1:0] beat_data(input int k);
    logic [DW*D-1:0] b;
    b[DW-1:0] = DW'(k + 1);
    for (int i = 1; i < D; i++) b[DW*i +: DW] = DW'(i);
    return b;
  endfunction

  // which: 0 = top (r-1), 1 = centre (r), 2 = bottom (r+1).
  function automatic logic [IMG_W-1:0] exp_window(input int r, input int which);
    logic [IMG_W-1:0] w;
    int src;
    w   = '0;
    src = r - 1 + which;
    if (src >= 0 && src < H)
      for (int j = 0; j < W; j++)
        for (int ch = 0; ch < D; ch++)
          w[DW*((W+2)*ch + j + 1) +: DW] = (ch == 0) ? DW'(src * W + j + 1) : DW'(ch);
    return w;
  endfunction

  function automatic logic [DW-1:0] px(input logic [IMG_W-1:0] img, input int ch, input int c);
    return img[DW*((W+2)*ch + c) +: DW];
  endfunction

  // Downstream stand-in: manual pulses, or auto done 5 cycles after each start.
  initial begin
    conv_done_i = 0;
    forever begin
      @(posedge clk);
      #1;
      conv_done_i = manual_done;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) conv_done_i = 1;
      end
      if (auto_done && image_start_o) done_cnt = 5;
    end
  end

  initial begin
    exp_row = 0;
    forever begin
      @(negedge clk);
      if (!rstn_i) exp_row = 0;
      else begin
        if (image_start_o) begin
          chk("row_idx", 64'(row_idx_o), 64'(exp_row));
          chk_img("win_top", image0_o, exp_window(exp_row, 0));
          chk_img("win_mid", image1_o, exp_window(exp_row, 1));
          chk_img("win_bot", image2_o, exp_window(exp_row, 2));
          exp_row++;
        end
        if (frame_done_o) begin
          chk("frame_rows", 64'(exp_row), 64'(H));
          exp_row = 0;
        end
      end
    end
  end

  task automatic drive(input int last, input bit gaps, input int stall_limit, output bit stalled);
    int idle;
    idle    = 0;
    stalled = 0;
    while (next_beat < last) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 1) == 0) begin
        pix_valid_i = 0;
        continue;
      end
      pix_valid_i = 1;
      pix_i       = beat_data(next_beat);
      if (pix_ready_o) begin
        next_beat++;
        idle = 0;
      end else begin
        idle++;
        if (idle >= stall_limit) begin
          stalled = 1;
          break;
        end
      end
    end
    @(negedge clk);
    pix_valid_i = 0;
  endtask

  task automatic pulse_done();
    manual_done = 1;
    @(negedge clk);
    manual_done = 0;
  endtask

  task automatic wait_start(input int maxc, input string nm);
    int n;
    n = 0;
    while (!image_start_o && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(image_start_o), 64'd1);
  endtask

  initial begin
    bit st;
    int n;
    bit seen;
    rstn_i      = 0;
    pix_valid_i = 0;
    pix_i       = '0;
    next_beat   = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(pix_ready_o), 64'd0);
    chk("rst_start", 64'(image_start_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_fdone", 64'(frame_done_o), 64'd0);
    chk("rst_rowidx", 64'(row_idx_o), 64'd0);
    chk_img("rst_img1", image1_o, '0);
    rstn_i = 1;
    @(negedge clk);
    chk("ready_after_rst", 64'(pix_ready_o), 64'd1);

    // Done while idle before any window: no effect.
    pulse_done();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (image_start_o) seen = 1;
    end
    chk("idle_done_start", 64'(seen), 64'd0);
    chk("idle_done_busy", 64'(busy_o), 64'd0);
    chk("idle_done_ready", 64'(pix_ready_o), 64'd1);

    // Row 0: start two cycles after the 24th beat is accepted.
    drive(24, 0, 200, st);
    chk("row0_stall", 64'(st), 64'd0);
    chk("row0_capture_cycle", 64'(image_start_o), 64'd0);
    @(negedge clk);
    chk("row0_latency", 64'(image_start_o), 64'd1);
    chk("row0_idx", 64'(row_idx_o), 64'd0);
    chk_img("row0_top_zero", image0_o, '0);
    chk("row0_mid_c0", 64'(px(image1_o, 0, 0)), 64'd0);
    chk("row0_mid_c1", 64'(px(image1_o, 0, 1)), 64'd1);
    chk("row0_mid_c12", 64'(px(image1_o, 0, 12)), 64'd12);
    chk("row0_mid_c13", 64'(px(image1_o, 0, 13)), 64'd0);
    chk("row0_bot_c1", 64'(px(image2_o, 0, 1)), 64'd13);
    chk("row0_bot_c12", 64'(px(image2_o, 0, 12)), 64'd24);
    chk("row0_bot_ch2_c5", 64'(px(image2_o, 2, 5)), 64'd2);
    chk("row0_bot_ch2_c0", 64'(px(image2_o, 2, 0)), 64'd0);
    chk("row0_bot_ch2_c13", 64'(px(image2_o, 2, 13)), 64'd0);
    chk("row0_busy", 64'(busy_o), 64'd1);

    // Backpressure: without done only rows 0..3 fit.
    drive(H * W, 0, 20, st);
    chk("bp_stalled", 64'(st), 64'd1);
    chk("bp_beats", 64'(next_beat), 64'd48);
    chk("bp_ready", 64'(pix_ready_o), 64'd0);
    pulse_done();
    wait_start(10, "row1_start");
    chk("row1_idx", 64'(row_idx_o), 64'd1);
    chk("row1_top_c1", 64'(px(image0_o, 0, 1)), 64'd1);
    chk("row1_top_c12", 64'(px(image0_o, 0, 12)), 64'd12);
    n = 0;
    while (!pix_ready_o && n < 5) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ready_back", 64'(pix_ready_o), 64'd1);

    // Rest of the frame with done 5 cycles after each start.
    auto_done = 1;
    pulse_done();
    drive(H * W, 0, 200, st);
    chk("frame_stall", 64'(st), 64'd0);
    n = 0;
    while (!(image_start_o && row_idx_o == 4'(H - 1)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("row11_start", 64'(image_start_o && row_idx_o == 4'(H - 1)), 64'd1);
    chk_img("row11_bot_zero", image2_o, '0);
    chk("row11_top_c1", 64'(px(image0_o, 0, 1)), 64'd121);
    chk("row11_top_c12", 64'(px(image0_o, 0, 12)), 64'd132);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!conv_done_i && n < 20);
    chk("last_done_seen", 64'(conv_done_i), 64'd1);
    @(negedge clk);
    chk("frame_done_pulse", 64'(frame_done_o), 64'd1);
    chk("frame_busy_low", 64'(busy_o), 64'd0);
    chk("frame_ready_new", 64'(pix_ready_o), 64'd1);
    @(negedge clk);
    chk("frame_done_once", 64'(frame_done_o), 64'd0);

    // Mid-frame reset, then a stray done.
    auto_done = 0;
    next_beat = 0;
    drive(30, 0, 200, st);
    chk("abort_stall", 64'(st), 64'd0);
    rstn_i = 0;
    #1;
    chk("abort_ready", 64'(pix_ready_o), 64'd0);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_rowidx", 64'(row_idx_o), 64'd0);
    chk_img("abort_img1", image1_o, '0);
    @(negedge clk);
    rstn_i = 1;
    pulse_done();
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (image_start_o) seen = 1;
    end
    chk("stray_done_start", 64'(seen), 64'd0);
    chk("stray_done_busy", 64'(busy_o), 64'd0);
    chk("stray_done_ready", 64'(pix_ready_o), 64'd1);

    // Fresh frame with random valid gaps; the model checks every window.
    auto_done = 1;
    next_beat = 0;
    drive(H * W, 1, 200, st);
    chk("gap_stall", 64'(st), 64'd0);
    n = 0;
    while (!frame_done_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("gap_frame_done", 64'(frame_done_o), 64'd1);
    chk("gap_busy_low", 64'(busy_o), 64'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv_row_feeder.md
Name: conv_row_feeder

Overview:
- Producer side of the conv row interface. Accepts a raster pixel stream, buffers rows in a 4-slot ring, and issues zero-padded 3-row windows (image0/1/2) with a one-cycle image_start_o.
- Waits for the conv/add result done before issuing the next window.
- Sits between the frame source and conv_top. One window per output row, H windows per frame.

Parameters:
D, 4, input channels per pixel beat
H, 12, image rows per frame (H >= 2)
W, 12, image columns per row
DATA_WIDTH, 8, bits per channel sample

Ports:
clk  in  1  clock, all logic on rising edge
rstn_i  in  1  asynchronous active-low reset
pix_i  in  DATA_WIDTH*D  one column beat; channel i at [DATA_WIDTH*i +: DATA_WIDTH]
pix_valid_i  in  1  pix_i valid
pix_ready_o  out  1  beat accepted when pix_valid_i && pix_ready_o
image0_o  out  DATA_WIDTH*D*(W+2)  window top row (r-1)
image1_o  out  DATA_WIDTH*D*(W+2)  window centre row (r)
image2_o  out  DATA_WIDTH*D*(W+2)  window bottom row (r+1)
image_start_o  out  1  one-cycle pulse: window valid
conv_done_i  in  1  downstream row result done (output_add_done_o)
row_idx_o  out  $clog2(H)  output row index r of the current window
frame_done_o  out  1  one-cycle pulse after done of row H-1
busy_o  out  1  high from first accepted beat to frame_done_o

Behaviour:
- Reset (async, rstn_i=0): every output is 0 and every counter is 0; pix_ready_o=0 while reset is asserted.
- pix_ready_o rises in the first cycle after reset release.
- Row data is not cleared on reset.
- Window layout: channel i occupies [DATA_WIDTH*(W+2)*(i+1)-1 : DATA_WIDTH*(W+2)*i] of each image.
  - Column c of that slice is [DATA_WIDTH*c +: DATA_WIDTH].
  - c=0 and c=W+1 are zero padding. Image column j maps to c=j+1.
- Input order: W beats per row, column 0 first; H rows per frame. Counters col_in and row_in.
  - Beat (row_in, col_in) is written to slot row_in mod 4.
- out_row is the next output row to issue.
  - Write permit: pix_ready_o = (row_in <= out_row+2) && (row_in < H) && state != WAIT_DONE_LAST.
  - Ready is registered; an accept on the cycle ready falls is not allowed.
- Issue condition: state IDLE and rows_complete >= min(out_row+2, H).
- FSM:
  - IDLE: when the issue condition holds, register the window, go to ISSUE.
    - image0_o = slot(out_row-1), or zeros if out_row=0.
    - image1_o = slot(out_row).
    - image2_o = slot(out_row+1), or zeros if out_row=H-1.
  - ISSUE (1 cycle): image_start_o=1, row_idx_o=out_row, out_row++. Go to WAIT_DONE, or WAIT_DONE_LAST if the issued row was H-1.
  - WAIT_DONE: on conv_done_i go to IDLE. Pixel acceptance continues per the write permit.
  - WAIT_DONE_LAST: pix_ready_o=0. On conv_done_i: frame_done_o=1 next cycle, all counters cleared, busy_o=0, go to IDLE, and the new frame is accepted.
- Latency: image_start_o is asserted 2 cycles after acceptance of the beat that completes the required row (capture cycle, then pulse). image*_o hold from that cycle until the next capture.
- conv_done_i in IDLE or ISSUE is ignored. A done coincident with the ISSUE cycle is ignored.
- pix_valid_i gaps are allowed; counters advance only on accept.
- A reset mid-frame aborts the frame. A conv_done_i that arrives later is ignored.
- No arithmetic. Pure data movement, bit-exact.

Test Plan:
- Reset: rstn_i=0 mid-run -> all outputs 0, pix_ready_o=0. After release, pix_ready_o=1 in the next cycle.
- Data setup: default params; channel 0 = row*12+col+1, channels 1..3 = channel index.
- Row 0: image_start_o 2 cycles after beat 24 is accepted. row_idx_o=0, image0_o=0. image1_o ch0 c=1..12 = 1..12, c=0 and c=13 = 0. image2_o ch0 = 13..24; ch2 columns = 2 except the pads.
- Backpressure: hold conv_done_i=0 after row 0 is issued -> exactly 48 beats (rows 0..3) accepted, then pix_ready_o=0. Pulse done -> row 1 issued (image0_o ch0 = 1..12) and ready reasserts.
- Last row: full frame with done pulsed 5 cycles after each start -> 12 starts with row_idx_o 0..11. Row 11 has image2_o=0 and image0_o ch0 = 121..132. frame_done_o pulses once, 1 cycle after the 12th done; busy_o falls.
- Spurious/late done: done in IDLE before any start -> no state change. Reset after 30 beats, then a stray done -> ignored. A fresh frame is issued correctly from row 0.
- Random valid gaps (50% duty) -> window contents identical to the gap-free run.
